// File: rtl/day1_pkg.sv
// Shared types and defaults for the day1 datapath primitives.
package day1_pkg;

  localparam int DAY1_WIDTH = 8;

  typedef logic [DAY1_WIDTH-1:0] day1_data_t;

endpackage : day1_pkg

// File: rtl/day1_mux2_core.sv
// Purely combinational WIDTH-bit 2:1 mux; an X/Z select propagates X in simulation.
module day1_mux2_core
  import day1_pkg::*;
#(
  parameter int WIDTH = DAY1_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // The ternary (rather than if/else) keeps an unknown select visible as X.
  assign y = sel ? b : a;

endmodule : day1_mux2_core

// File: rtl/day1_mux2.sv
// 2:1 data mux with a combinational output and a flop-bounded copy of the same result.
module day1_mux2
  import day1_pkg::*;
#(
  parameter int               WIDTH   = DAY1_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] y_q_o
);

  logic [WIDTH-1:0] y_mux;

  day1_mux2_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a   (a_i),
    .b   (b_i),
    .sel (sel_i),
    .y   (y_mux)
  );

  assign y_o = y_mux;

  // y_o stays independent of reset; only the registered copy is cleared.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      y_q_o <= RST_VAL;
    end else begin
      y_q_o <= y_mux;
    end
  end

endmodule : day1_mux2

// File: tb/tb_day1_mux2.sv
// Self-checking bench for day1_mux2: directed literal checks plus randomized traffic vs a reference model.
module tb_day1_mux2;
  import day1_pkg::*;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  day1_data_t a;
  day1_data_t b;
  logic       sel;
  day1_data_t y;
  day1_data_t y_q;

  int tests;
  int fails;

  day1_data_t exp_q;
  logic       cmp_en;

  day1_mux2 #(
    .WIDTH   (DAY1_WIDTH),
    .RST_VAL (8'h00)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .a_i     (a),
    .b_i     (b),
    .sel_i   (sel),
    .y_o     (y),
    .y_q_o   (y_q)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  function automatic day1_data_t ref_mux(day1_data_t da, day1_data_t db, logic s);
    return (s == 1'b1) ? db : da;
  endfunction

  task automatic check(input string name, input day1_data_t act, input day1_data_t req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %02h, expected %02h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference register: holds the last mux value seen at a clock edge out of reset.
  always @(negedge rst_n) exp_q = 8'h00;
  always @(posedge clk) begin
    if (!rst_n) exp_q = 8'h00;
    else        exp_q = ref_mux(a, b, sel);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_y", y, ref_mux(a, b, sel));
      check("cyc_y_q", y_q, exp_q);
    end
  end

  task automatic drive(input day1_data_t da, input day1_data_t db, input logic s);
    a   = da;
    b   = db;
    sel = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    day1_data_t tab_a [3] = '{8'h00, 8'h12, 8'h56};
    day1_data_t tab_b [3] = '{8'h11, 8'h34, 8'h78};
    day1_data_t sel0_exp [3] = '{8'h00, 8'h12, 8'h56};
    day1_data_t sel1_a [3] = '{8'h56, 8'h00, 8'h12};
    day1_data_t sel1_b [3] = '{8'h78, 8'h11, 8'h34};
    day1_data_t sel1_exp [3] = '{8'h78, 8'h11, 8'h34};

    tests  = 0;
    fails  = 0;
    cmp_en = 1'b0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    exp_q  = 8'h00;
    drive(8'h00, 8'h00, 1'b0);
    #1;
    rst_n = 1'b0;

    // No clock, reset held: y follows inputs, y_q sits at reset value.
    for (int i = 0; i < 3; i++) begin
      drive(tab_a[i], tab_b[i], 1'b0);
      #1;
      check("sel0_y", y, sel0_exp[i]);
      check("rst_y_q", y_q, 8'h00);
      #9;
    end
    for (int i = 0; i < 3; i++) begin
      drive(sel1_a[i], sel1_b[i], 1'b1);
      #1;
      check("sel1_y", y, sel1_exp[i]);
      check("rst_y_q", y_q, 8'h00);
      #9;
    end

    // Clock runs under reset; y_q must stay at reset value.
    clk_en = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clk_y_q", y_q, 8'h00);

    // Release and load A5 through b.
    #1;
    rst_n = 1'b1;
    drive(8'h00, 8'hA5, 1'b1);
    #1;
    check("a5_y_now", y, 8'hA5);
    check("a5_y_q_before", y_q, 8'h00);
    @(posedge clk);
    #1;
    check("a5_y_q", y_q, 8'hA5);

    // Mid-run async reset between edges.
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_y_q", y_q, 8'h00);
    check("async_rst_y", y, 8'hA5);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(8'h5A, 8'hA5, 1'b0);
    #1;
    check("post_rel_y_q_hold", y_q, 8'h00);
    @(posedge clk);
    #1;
    check("reload_y_q", y_q, 8'h5A);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 19) == 0) rst_n = ~rst_n;
      else if (!rst_n) rst_n = 1'b1;
      drive(day1_data_t'($urandom), day1_data_t'($urandom), 1'($urandom));
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Unselected input toggles: outputs pinned to a.
    drive(8'h3C, 8'h00, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      #2;
      b = day1_data_t'($urandom);
      #1;
      check("unsel_y", y, 8'h3C);
      check("unsel_y_q", y_q, 8'h3C);
      @(posedge clk);
    end

    #1;
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_day1_mux2
